timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one internal cycle timer among N_REQ requesters, each asking for its own duration.
- Arbitration is round-robin. The winner holds a one-hot grant for exactly its requested number of enabled cycles, then receives a one-cycle done pulse.
- Sits between control FSMs that need timed waits and the single timer resource, so each FSM does not need its own counter.
- Self-contained: the counter is internal to this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CNT_W, 8, width of the duration fields and of the counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  global run enable. Low pauses the count and blocks new grants.
- req  input  N_REQ  per-requester level request. It must stay high until done; dropping it aborts.
- dur  input  N_REQ*CNT_W  packed durations; requester i uses bits [i*CNT_W +: CNT_W].
- grant  output  N_REQ  one-hot owner of the timer; all zero when no one owns it.
- done  output  N_REQ  one-cycle completion pulse to the owner.
- busy  output  1  high while the state is RUN or DONE.
- count  output  CNT_W  current elapsed count of the running job.

Behaviour:
- All outputs are registered.
- Reset: when reset==0 at a clk edge, the block applies:
  - state=IDLE, grant=0, done=0, busy=0, count=0;
  - round-robin pointer ptr=0, captured duration dlen=0, owner index own=0.
  - Reset overrides everything, including a job in RUN mid-count. No done pulse is issued for the killed job.
- States: IDLE, RUN, DONE.
- IDLE:
  - If enable==1 and req!=0: select the first i with req[i]==1, searching ptr, ptr+1, ... modulo N_REQ.
  - Capture own=i and dlen=dur[i]. A dur value of 0 is treated as 1.
  - Next cycle: state=RUN, grant[i]=1, busy=1, count=0.
  - If enable==0 or req==0: stay in IDLE.
- RUN:
  - Abort: if req[own]==0, the next cycle has state=IDLE, grant=0, busy=0, count=0, no done, and ptr=own+1 (mod N_REQ). Abort takes priority over completion in the same cycle.
  - Pause: else if enable==0, count holds and grant holds.
  - Complete: else if count==dlen-1, the next cycle has state=DONE, grant=0, done[own]=1, count=0.
  - Otherwise count increments by 1.
  - Timing: with no pauses, grant is high for exactly dlen cycles, and count shows 0..dlen-1 during those cycles.
- DONE:
  - Lasts exactly one cycle: done[own]=1, busy=1, grant=0.
  - Next cycle: state=IDLE, done=0, busy=0, ptr=own+1 (mod N_REQ).
  - enable is ignored in DONE.
- Latency: request sampled in IDLE at cycle t gives:
  - grant at t+1..t+dlen;
  - done at t+dlen+1;
  - IDLE at t+dlen+2;
  - next grant at the earliest t+dlen+3.
- Duration changes: dur and non-owner req changes while in RUN or DONE are ignored. dlen is frozen at the grant decision.
- Simultaneous requests: round-robin from ptr only. A requester that was just served has the lowest priority in the next arbitration.
- Arithmetic and wrap-around:
  - count never wraps, because the maximum dlen is 2^CNT_W-1.
  - ptr wraps from N_REQ-1 to 0.
- Invariants: grant is one-hot or zero. done is one-hot or zero. grant and done are never high on the same cycle.

Test Plan (N_REQ=4, CNT_W=8):
- Single job: reset low 2 cycles, then high. req=4'b0010, dur[1]=5, enable=1.
  - Expected: grant=4'b0010 for 5 cycles, count 0,1,2,3,4.
  - Then done=4'b0010 for 1 cycle, then busy=0.
- Round-robin fairness: req=4'b1111 held, all dur=3.
  - Expected: grant order 0,1,2,3,0 (4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001).
  - Each grant lasts 3 cycles and is followed by its own done pulse.
- Pause: dur[2]=10, req[2]=1. Drop enable for 4 cycles while count==3.
  - Expected: count holds at 3 and grant stays high.
  - Total grant time is 14 cycles; done occurs after count==9.
- Abort: dur[0]=20, req[0] dropped when count==7.
  - Expected: next cycle grant=0, no done pulse, state IDLE.
  - A pending req[1] is granted next, since ptr=1.
- Edge durations:
  - dur=0: grant lasts 1 cycle, then done.
  - dur=255: grant lasts 255 cycles, count peaks at 254, done follows.
- Reset mid-RUN: pull reset low at count==4 of a dur=8 job.
  - Expected at the next edge: grant=0, done=0, busy=0, count=0.
  - After reset releases with req=4'b1111, arbitration restarts at requester 0.

Source files
------------

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin arbiter that lends one internal cycle timer to
//               N_REQ requesters. The winner holds a one-hot grant for its
//               requested number of enabled cycles, then gets a one-cycle
//               done pulse. Dropping the request aborts the job silently.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dur,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_own;
    logic [CNT_W-1:0]     r_dlen;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     r_done;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_count;

    state_t               w_state;
    logic [c_IDX_W-1:0]   w_ptr;
    logic [c_IDX_W-1:0]   w_own;
    logic [CNT_W-1:0]     w_dlen;
    logic [N_REQ-1:0]     w_grant;
    logic [N_REQ-1:0]     w_done;
    logic                 w_busy;
    logic [CNT_W-1:0]     w_count;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_sel;
    logic [c_IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]     w_sel_dur;
    logic [CNT_W-1:0]     w_sel_dlen;
    logic [c_IDX_W-1:0]   w_ptr_after;
    logic                 w_last;

    // Round-robin search: first active request starting at r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(r_ptr) + k >= N_REQ) begin
                w_idx = c_IDX_W'(int'(r_ptr) + k - N_REQ);
            end else begin
                w_idx = c_IDX_W'(int'(r_ptr) + k);
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // A zero duration is promoted to one cycle so the job always completes.
    assign w_sel_dur   = dur[int'(w_sel)*CNT_W +: CNT_W];
    assign w_sel_dlen  = (w_sel_dur == '0) ? CNT_W'(1) : w_sel_dur;
    // The just-served requester drops to lowest priority next time round.
    assign w_ptr_after = (r_own == c_IDX_W'(N_REQ - 1)) ? '0 : r_own + c_IDX_W'(1);
    assign w_last      = (r_count == r_dlen - CNT_W'(1));

    // Next-state and next-output decode; every register gets a hold default.
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_own   = r_own;
        w_dlen  = r_dlen;
        w_grant = r_grant;
        w_done  = '0;
        w_busy  = r_busy;
        w_count = r_count;
        case (r_state)
            IDLE: begin
                w_grant = '0;
                w_busy  = 1'b0;
                w_count = '0;
                if (enable && w_found) begin
                    w_state = RUN;
                    w_own   = w_sel;
                    w_dlen  = w_sel_dlen;
                    w_grant = N_REQ'(1) << w_sel;
                    w_busy  = 1'b1;
                end
            end
            RUN: begin
                if (!req[r_own]) begin
                    // Abort beats completion; no done pulse for this job.
                    w_state = IDLE;
                    w_grant = '0;
                    w_busy  = 1'b0;
                    w_count = '0;
                    w_ptr   = w_ptr_after;
                end else if (!enable) begin
                    w_count = r_count;
                end else if (w_last) begin
                    w_state = DONE;
                    w_grant = '0;
                    w_done  = N_REQ'(1) << r_own;
                    w_count = '0;
                end else begin
                    w_count = r_count + CNT_W'(1);
                end
            end
            DONE: begin
                w_state = IDLE;
                w_grant = '0;
                w_busy  = 1'b0;
                w_count = '0;
                w_ptr   = w_ptr_after;
            end
            default: begin
                w_state = IDLE;
                w_grant = '0;
                w_busy  = 1'b0;
                w_count = '0;
            end
        endcase
    end

    // State and output registers; reset kills any running job outright.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_dlen  <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_own   <= w_own;
            r_dlen  <= w_dlen;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_count <= w_count;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Self-checking bench for timer_arbiter (N_REQ=4, CNT_W=8).
//               Each scenario queues the expected per-cycle output stream and
//               compares it against the DUT cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int c_N = 4;
    localparam int c_W = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [c_N-1:0]   req;
    logic [c_N*c_W-1:0] dur;
    logic [c_N-1:0]   grant;
    logic [c_N-1:0]   done;
    logic             busy;
    logic [c_W-1:0]   count;

    typedef struct {
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;

    timer_arbiter #(.N_REQ(c_N), .CNT_W(c_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .req    (req),
        .dur    (dur),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .count  (count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] d, input logic b, input logic [7:0] c);
        exp_t x;
        x.g = g; x.d = d; x.b = b; x.c = c;
        sb.push_back(x);
    endtask

    // Queue a full job: n grant cycles, a done pulse, then one idle cycle.
    task automatic push_job(input int who, input int n);
        for (int k = 0; k < n; k++) push(4'(1 << who), 4'b0, 1'b1, 8'(k));
        push(4'b0, 4'(1 << who), 1'b1, 8'd0);
        push(4'b0, 4'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; enable = 1'b1; dur = '0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b1111; enable = 1'b1; dur = '0;
        tick(); tick();
        checks++;
        if ({grant, done, busy, count} !== 17'd0) begin
            errors++;
            $display("FAIL reset grant=%b done=%b busy=%b count=%0d expected all zero", grant, done, busy, count);
        end
        req = '0;
        reset = 1'b1;
        tick();
        checks++;
        if ({grant, busy} !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle grant=%b busy=%b expected 0/0", grant, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010; dur[1*c_W +: c_W] = 8'd5;
        push_job(1, 5);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL single[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 5) req = '0;
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < c_N; r++) dur[r*c_W +: c_W] = 8'd3;
        for (int j = 0; j < 5; j++) push_job(order[j], 3);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL round_robin[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 23) req = '0;
        end
    endtask

    task automatic test_pause();
        do_reset();
        req = 4'b0100; dur[2*c_W +: c_W] = 8'd10;
        for (int k = 0; k < 4; k++) push(4'b0100, 4'b0, 1'b1, 8'(k));
        for (int k = 0; k < 4; k++) push(4'b0100, 4'b0, 1'b1, 8'd3);
        for (int k = 4; k < 10; k++) push(4'b0100, 4'b0, 1'b1, 8'(k));
        push(4'b0, 4'b0100, 1'b1, 8'd0);
        push(4'b0, 4'b0, 1'b0, 8'd0);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL pause[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 3)  enable = 1'b0;
            if (i == 7)  enable = 1'b1;
            if (i == 14) req = '0;
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0011; dur[0*c_W +: c_W] = 8'd20; dur[1*c_W +: c_W] = 8'd2;
        for (int k = 0; k < 8; k++) push(4'b0001, 4'b0, 1'b1, 8'(k));
        push(4'b0, 4'b0, 1'b0, 8'd0);
        push_job(1, 2);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL abort[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 7)  req = 4'b0010;
            if (i == 11) req = '0;
        end
    endtask

    task automatic test_edge_durations();
        do_reset();
        req = 4'b0001; dur[0*c_W +: c_W] = 8'd0;
        push_job(0, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL dur0[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 1) req = '0;
        end
        // ptr is now 1; requester 1 is chosen directly.
        req = 4'b0010; dur[1*c_W +: c_W] = 8'd255;
        push_job(1, 255);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL dur255[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 255) req = '0;
        end
    endtask

    task automatic test_reset_mid_run();
        // ptr is 2 after the previous job; requester 2 wins.
        req = 4'b0100; dur[2*c_W +: c_W] = 8'd8;
        for (int k = 0; k < 5; k++) push(4'b0100, 4'b0, 1'b1, 8'(k));
        push(4'b0, 4'b0, 1'b0, 8'd0);
        push_job(0, 2);
        for (int i = 0; sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({grant, done, busy, count} !== {e.g, e.d, e.b, e.c}) begin
                errors++;
                $display("FAIL reset_mid_run[%0d] got g=%b d=%b b=%b c=%0d want g=%b d=%b b=%b c=%0d",
                         i, grant, done, busy, count, e.g, e.d, e.b, e.c);
            end
            if (i == 4) reset = 1'b0;
            if (i == 5) begin
                reset = 1'b1;
                req   = 4'b1111;
                for (int r = 0; r < c_N; r++) dur[r*c_W +: c_W] = 8'd2;
            end
            if (i == 8) req = '0;
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b0;
        req    = '0;
        dur    = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_abort();
        test_edge_durations();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
